// File: rtl/obi_rom_pipelined.sv
// obi_rom_pipelined: parametrised read-only OBI subordinate with a fixed-latency response pipeline
package obi_pkg;
  typedef struct packed {
    int unsigned addr_width;
    int unsigned data_width;
    int unsigned id_width;
  } obi_cfg_t;
  localparam obi_cfg_t ObiDefaultConfig = '{addr_width: 32, data_width: 32, id_width: 4};
  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [3:0]  aid;
  } obi_a_chan_t;
  typedef struct packed {
    obi_a_chan_t a;
    logic        req;
  } obi_req_t;
  typedef struct packed {
    logic [31:0] rdata;
    logic [3:0]  rid;
    logic        err;
    logic        r_optional;
  } obi_r_chan_t;
  typedef struct packed {
    obi_r_chan_t r;
    logic        gnt;
    logic        rvalid;
  } obi_rsp_t;
endpackage

module obi_rom_pipelined #(
  parameter obi_pkg::obi_cfg_t ObiCfg = obi_pkg::ObiDefaultConfig,
  parameter type obi_req_t = obi_pkg::obi_req_t,
  parameter type obi_rsp_t = obi_pkg::obi_rsp_t,
  parameter int unsigned NumWords = 8,
  parameter int unsigned Latency = 2,
  parameter logic [NumWords-1:0][31:0] Contents = '0
) (
  input  logic     clk_i,
  input  logic     rst_i,
  input  obi_req_t obi_req_i,
  output obi_rsp_t obi_rsp_o
);
  localparam int unsigned IdxW = NumWords > 1 ? $clog2(NumWords) : 1;
  localparam int unsigned IdW = ObiCfg.id_width;
  if (ObiCfg.data_width != 32) begin : g_bad_dw
    $fatal(1, "obi_rom_pipelined: data width must be 32");
  end
  if (Latency < 1 || Latency > 4) begin : g_bad_lat
    $fatal(1, "obi_rom_pipelined: Latency must be 1..4");
  end
  if (NumWords < 1 || NumWords > 256) begin : g_bad_nw
    $fatal(1, "obi_rom_pipelined: NumWords must be 1..256");
  end
  typedef struct packed {
    logic           valid;
    logic [IdW-1:0] id;
    logic           err;
    logic [31:0]    data;
  } stage_t;
  stage_t [Latency-1:0] pipe;
  stage_t               s0;
  logic [IdxW-1:0]      idx;
  logic                 acc_err;
  logic                 unused_req;
  assign unused_req = ^obi_req_i;
  // idle stages carry zeros so the registered outputs read 0 whenever rvalid is low
  always_comb begin
    idx      = obi_req_i.a.addr[IdxW+1:2];
    acc_err  = obi_req_i.a.we | (obi_req_i.a.addr[1:0] != 2'b00) | (32'(idx) >= NumWords);
    s0.valid = obi_req_i.req;
    s0.id    = obi_req_i.req ? obi_req_i.a.aid : '0;
    s0.err   = obi_req_i.req & acc_err;
    s0.data  = (obi_req_i.req && !acc_err) ? Contents[idx] : '0;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pipe <= '0;
    end else begin
      pipe[0] <= s0;
      for (int i = 1; i < Latency; i++) pipe[i] <= pipe[i-1];
    end
  end
  always_comb begin
    obi_rsp_o         = '0;
    obi_rsp_o.gnt     = obi_req_i.req;
    obi_rsp_o.rvalid  = pipe[Latency-1].valid;
    obi_rsp_o.r.rid   = pipe[Latency-1].id;
    obi_rsp_o.r.err   = pipe[Latency-1].err;
    obi_rsp_o.r.rdata = pipe[Latency-1].data;
  end
endmodule

// File: tb/tb_obi_rom_pipelined.sv
// tb_obi_rom_pipelined: five ROM configurations driven in lockstep, checked by a per-instance scoreboard
module tb_obi_rom_pipelined;
  import obi_pkg::*;
  localparam int ND = 5;
  localparam int LAT [ND] = '{2, 2, 3, 1, 4};
  localparam int NW [ND] = '{8, 5, 8, 8, 5};
  localparam logic [7:0][31:0] ROM = {32'h21216e69, 32'h61686320, 32'h6f726963, 32'h6c6c6564,
                                      32'h61202c6f, 32'h6c6c6548, 32'h20706968, 32'h7567694d};
  typedef struct {
    int          due;
    logic [3:0]  id;
    logic        err;
    logic [31:0] data;
  } exp_t;
  logic     clk = 1'b0;
  logic     rst = 1'b1;
  obi_req_t req = '0;
  obi_rsp_t rsp [ND];
  exp_t     sb [ND][$];
  int       cyc = 0;
  int       compared = 0;
  int       mismatched = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < ND; g++) begin : g_dut
    obi_rom_pipelined #(
      .NumWords(NW[g]),
      .Latency (LAT[g]),
      .Contents(ROM[NW[g]-1:0])
    ) u_dut (
      .clk_i    (clk),
      .rst_i    (rst),
      .obi_req_i(req),
      .obi_rsp_o(rsp[g])
    );
  end
  function automatic exp_t model(int k, logic [31:0] addr, logic we, logic [3:0] aid);
    int   idx;
    exp_t e;
    idx    = int'(addr[4:2]);
    e.due  = cyc + LAT[k];
    e.id   = aid;
    e.err  = we || addr[1:0] != 2'b00 || idx >= NW[k];
    e.data = e.err ? 32'h0 : ROM[idx];
    return e;
  endfunction
  task automatic drive(input logic r, input logic [31:0] addr, input logic we, input logic [3:0] aid);
    req         = '0;
    req.req     = r;
    req.a.addr  = addr;
    req.a.we    = we;
    req.a.aid   = aid;
    req.a.be    = 4'hF;
    req.a.wdata = 32'hFFFFFFFF;
    if (r && !rst) for (int k = 0; k < ND; k++) sb[k].push_back(model(k, addr, we, aid));
  endtask
  task automatic tick(input logic rst_next);
    exp_t e;
    logic hit;
    @(negedge clk);
    for (int k = 0; k < ND; k++) begin
      hit = sb[k].size() > 0 && sb[k][0].due == cyc;
      e   = hit ? sb[k].pop_front() : '{0, 4'h0, 1'b0, 32'h0};
      compared++;
      if ({rsp[k].rvalid, rsp[k].r.rid, rsp[k].r.err, rsp[k].r.rdata} !== {hit, e.id, e.err, e.data}) begin
        mismatched++;
        $display("FAIL rsp dut%0d cyc%0d: got v=%b id=%h err=%b data=%h, want v=%b id=%h err=%b data=%h",
                 k, cyc, rsp[k].rvalid, rsp[k].r.rid, rsp[k].r.err, rsp[k].r.rdata, hit, e.id, e.err, e.data);
      end
      compared++;
      if (rsp[k].gnt !== req.req || rsp[k].r.r_optional !== 1'b0) begin
        mismatched++;
        $display("FAIL gnt dut%0d cyc%0d: got gnt=%b ropt=%b, want gnt=%b ropt=0",
                 k, cyc, rsp[k].gnt, rsp[k].r.r_optional, req.req);
      end
    end
    rst = rst_next;
    if (rst_next) for (int k = 0; k < ND; k++) sb[k].delete();
    @(posedge clk);
    #1;
    cyc++;
  endtask
  task automatic test_reset();
    drive(1'b1, 32'h0, 1'b0, 4'h5);
    tick(1'b1);
    tick(1'b1);
    for (int k = 0; k < ND; k++) begin
      compared++;
      if (rsp[k].rvalid !== 1'b0 || rsp[k].r.rdata !== 32'h0 || rsp[k].r.rid !== 4'h0 ||
          rsp[k].r.err !== 1'b0 || rsp[k].gnt !== 1'b1) begin
        mismatched++;
        $display("FAIL reset dut%0d: got v=%b data=%h id=%h err=%b gnt=%b, want all 0 and gnt=1",
                 k, rsp[k].rvalid, rsp[k].r.rdata, rsp[k].r.rid, rsp[k].r.err, rsp[k].gnt);
      end
    end
    drive(1'b0, 32'h0, 1'b0, 4'h0);
    tick(1'b0);
    tick(1'b0);
  endtask
  task automatic test_single();
    drive(1'b1, 32'h0, 1'b0, 4'h3);
    tick(1'b0);
    drive(1'b0, 32'h0, 1'b0, 4'h0);
    tick(1'b0);
    compared++;
    if (rsp[0].rvalid !== 1'b1 || rsp[0].r.rdata !== 32'h7567694d || rsp[0].r.rid !== 4'h3 || rsp[0].r.err !== 1'b0) begin
      mismatched++;
      $display("FAIL single: got v=%b data=%h id=%h err=%b, want v=1 data=7567694d id=3 err=0",
               rsp[0].rvalid, rsp[0].r.rdata, rsp[0].r.rid, rsp[0].r.err);
    end
    repeat (4) tick(1'b0);
  endtask
  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 32'(i * 4), 1'b0, 4'(i));
      tick(1'b0);
    end
    drive(1'b0, 32'h0, 1'b0, 4'h0);
    repeat (6) tick(1'b0);
  endtask
  task automatic test_write_err();
    drive(1'b1, 32'h8, 1'b1, 4'h1);
    tick(1'b0);
    drive(1'b1, 32'h8, 1'b0, 4'h2);
    tick(1'b0);
    drive(1'b0, 32'h0, 1'b0, 4'h0);
    repeat (6) tick(1'b0);
  endtask
  task automatic test_range();
    drive(1'b1, 32'h14, 1'b0, 4'h4);
    tick(1'b0);
    drive(1'b1, 32'h10, 1'b0, 4'h5);
    tick(1'b0);
    drive(1'b1, 32'h2, 1'b0, 4'h6);
    tick(1'b0);
    drive(1'b1, 32'h28, 1'b0, 4'h7);
    tick(1'b0);
    drive(1'b0, 32'h0, 1'b0, 4'h0);
    repeat (6) tick(1'b0);
  endtask
  task automatic test_reset_flush();
    drive(1'b1, 32'h0, 1'b0, 4'h1);
    tick(1'b0);
    drive(1'b1, 32'h4, 1'b0, 4'h2);
    tick(1'b0);
    drive(1'b1, 32'h8, 1'b0, 4'h3);
    tick(1'b1);
    drive(1'b0, 32'h0, 1'b0, 4'h0);
    tick(1'b0);
    repeat (6) begin
      tick(1'b0);
      compared++;
      if (rsp[2].rvalid !== 1'b0) begin
        mismatched++;
        $display("FAIL flush cyc%0d: got rvalid=%b, want 0", cyc, rsp[2].rvalid);
      end
    end
    drive(1'b1, 32'hC, 1'b0, 4'h4);
    tick(1'b0);
    drive(1'b0, 32'h0, 1'b0, 4'h0);
    repeat (6) tick(1'b0);
  endtask
  task automatic test_random();
    logic [31:0] addr;
    for (int i = 0; i < 1000; i++) begin
      addr = $urandom();
      if ($urandom_range(0, 4) != 0) addr[1:0] = 2'b00;
      drive($urandom_range(0, 9) < 6, addr, $urandom_range(0, 9) == 0, 4'($urandom()));
      tick(1'b0);
    end
    drive(1'b0, 32'h0, 1'b0, 4'h0);
    repeat (6) tick(1'b0);
    for (int k = 0; k < ND; k++) begin
      compared++;
      if (sb[k].size() != 0) begin
        mismatched++;
        $display("FAIL drain dut%0d: got %0d pending, want 0", k, sb[k].size());
      end
    end
  endtask
  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_write_err();
    test_range();
    test_reset_flush();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
